// File: rtl/complex_pkg.sv
// Shared definitions for the complex-vector datapath blocks: the default
// element width, the assembler FSM state type and per-element helpers.
// A complex element packs its real part in the upper half and its
// imaginary part in the lower half.
package complex_pkg;

  localparam int DEFAULT_ELEMENT_WIDTH = 64;
  localparam int DEFAULT_HALF_WIDTH    = DEFAULT_ELEMENT_WIDTH / 2;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [DEFAULT_HALF_WIDTH-1:0] re_part(
    input logic [DEFAULT_ELEMENT_WIDTH-1:0] e
  );
    return e[DEFAULT_ELEMENT_WIDTH-1:DEFAULT_HALF_WIDTH];
  endfunction

  function automatic logic [DEFAULT_HALF_WIDTH-1:0] im_part(
    input logic [DEFAULT_ELEMENT_WIDTH-1:0] e
  );
    return e[DEFAULT_HALF_WIDTH-1:0];
  endfunction

  // Two's-complement negation wraps, so the most-negative imaginary value
  // maps onto itself.
  function automatic logic [DEFAULT_ELEMENT_WIDTH-1:0] conj(
    input logic [DEFAULT_ELEMENT_WIDTH-1:0] e
  );
    logic [DEFAULT_HALF_WIDTH-1:0] negIm;
    negIm = ~im_part(e) + 1'b1;
    return {re_part(e), negIm};
  endfunction

endpackage

// File: rtl/complex_chunk_conj.sv
// Combinational conjugation of one chunk of NI/2 complex elements.
// Each element keeps its real half and has its imaginary half negated
// (two's complement, wrapping) when conj_i is set; otherwise the chunk
// passes through untouched.
module complex_chunk_conj #(
  parameter int NI            = 8,
  parameter int ELEMENT_WIDTH = 64
) (
  input  logic [ELEMENT_WIDTH*(NI/2)-1:0] data_i,
  input  logic                            conj_i,
  output logic [ELEMENT_WIDTH*(NI/2)-1:0] data_o
);

  localparam int HALF_W = ELEMENT_WIDTH / 2;

  for (genvar e = 0; e < NI / 2; e++) begin : g_elem
    logic [HALF_W-1:0] rePart;
    logic [HALF_W-1:0] imPart;
    logic [HALF_W-1:0] negIm;

    assign rePart = data_i[e*ELEMENT_WIDTH+HALF_W +: HALF_W];
    assign imPart = data_i[e*ELEMENT_WIDTH +: HALF_W];
    assign negIm  = ~imPart + 1'b1;
    assign data_o[e*ELEMENT_WIDTH +: ELEMENT_WIDTH] =
      conj_i ? {rePart, negIm} : {rePart, imPart};
  end

endmodule

// File: rtl/complex_vector_demux_assembler.sv
// Collects NUM_SLOTS chunks of NI/2 complex elements into one wide vector.
// Chunks are steered either by an internal wrapping pointer (auto mode)
// or by in_sel (addressed mode). A full mask, or a flush with at least one
// slot written, moves the block into HOLD where the vector is offered on a
// valid/ready port; the handshake clears everything and re-opens the input.
// Optional build macro COMPLEX_DEMUX_CONJ_EN adds the in_conj port, which
// stores the conjugate of the incoming chunk.
module complex_vector_demux_assembler
  import complex_pkg::*;
#(
  parameter int NI            = 8,
  parameter int ELEMENT_WIDTH = DEFAULT_ELEMENT_WIDTH,
  parameter int NUM_SLOTS     = 2,
  localparam int CHUNK_W      = ELEMENT_WIDTH * (NI / 2),
  localparam int OUT_W        = CHUNK_W * NUM_SLOTS,
  localparam int SEL_W        = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CHUNK_W-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 addr_mode,
  input  logic                 flush,
`ifdef COMPLEX_DEMUX_CONJ_EN
  input  logic                 in_conj,
`endif
  output logic [OUT_W-1:0]     out_data,
  output logic [NUM_SLOTS-1:0] out_mask,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err_sel,
  output logic                 err_ovw
);

  localparam logic [SEL_W-1:0] LAST_PTR   = SEL_W'(NUM_SLOTS - 1);
  localparam logic [SEL_W:0]   SLOT_COUNT = (SEL_W + 1)'(NUM_SLOTS);

  state_t               state_q, state_d;
  logic [OUT_W-1:0]     slots_q, slots_d;
  logic [NUM_SLOTS-1:0] mask_q, mask_d;
  logic [SEL_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic                 err_sel_q, err_sel_d;
  logic                 err_ovw_q, err_ovw_d;

  logic                 accept;
  logic [SEL_W-1:0]     target;
  logic                 selOk;
  logic [CHUNK_W-1:0]   storeData;

  assign accept = in_valid && (state_q == FILL);
  assign target = addr_mode ? in_sel : wr_ptr_q;
  // Only addressed writes can point past the last slot; the auto pointer
  // always stays in range.
  assign selOk  = !addr_mode || ({1'b0, in_sel} < SLOT_COUNT);

`ifdef COMPLEX_DEMUX_CONJ_EN
  complex_chunk_conj #(
    .NI            (NI),
    .ELEMENT_WIDTH (ELEMENT_WIDTH)
  ) u_conj (
    .data_i (in_data),
    .conj_i (in_conj),
    .data_o (storeData)
  );
`else
  assign storeData = in_data;
`endif

  // Next-state logic: slot writes, pointer advance, error pulses and the
  // FILL/HOLD transitions (completion, flush, output handshake).
  always_comb begin
    state_d   = state_q;
    slots_d   = slots_q;
    mask_d    = mask_q;
    wr_ptr_d  = wr_ptr_q;
    err_sel_d = 1'b0;
    err_ovw_d = 1'b0;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (!selOk) begin
            err_sel_d = 1'b1;
          end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
              if (target == SEL_W'(k)) begin
                err_ovw_d                    = mask_q[k];
                slots_d[k*CHUNK_W +: CHUNK_W] = storeData;
                mask_d[k]                     = 1'b1;
              end
            end
          end
          if (!addr_mode) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
          end
        end
        if (&mask_d) begin
          state_d = HOLD;
        end else if (flush && (|mask_d)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d  = FILL;
          slots_d  = '0;
          mask_d   = '0;
          wr_ptr_d = '0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State registers with synchronous active-low reset that drops any
  // partial or held vector.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      slots_q   <= '0;
      mask_q    <= '0;
      wr_ptr_q  <= '0;
      err_sel_q <= 1'b0;
      err_ovw_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slots_q   <= slots_d;
      mask_q    <= mask_d;
      wr_ptr_q  <= wr_ptr_d;
      err_sel_q <= err_sel_d;
      err_ovw_q <= err_ovw_d;
    end
  end

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out_data  = slots_q;
  assign out_mask  = mask_q;
  assign err_sel   = err_sel_q;
  assign err_ovw   = err_ovw_q;

endmodule

// File: tb/tb_complex_vector_demux_assembler.sv
// Testbench for complex_vector_demux_assembler. Two instances share one
// stimulus stream: the classic 2-slot build and a 3-slot build (whose
// 2-bit in_sel can address a non-existent slot). A slot-array reference
// model predicts every output each cycle.
module tb_complex_vector_demux_assembler;

  localparam int NI = 8;
  localparam int EW = 64;
  localparam int CW = EW * (NI / 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] in_data;
  logic          in_valid;
  logic [1:0]    in_sel;
  logic          addr_mode;
  logic          flush;
  logic          out_ready;
  logic          in_conj;

  logic          inReady2, outValid2, errSel2, errOvw2;
  logic [511:0]  outData2;
  logic [1:0]    outMask2;
  logic          inReady3, outValid3, errSel3, errOvw3;
  logic [767:0]  outData3;
  logic [2:0]    outMask3;

  logic          oReady[2], oValid[2], oErrSel[2], oErrOvw[2];
  logic [767:0]  oData[2];
  logic [2:0]    oMask[2];

  int   nSlots[2] = '{2, 3};
  bit   mHold[2];
  bit   mFilled[2][3];
  logic [CW-1:0] mSlot[2][3];
  int   mPtr[2];
  bit   mErrSel[2], mErrOvw[2];

  int   assertCount = 0;
  int   failCount   = 0;

  logic [CW-1:0] chunkA, chunkB, chunkC, chunkD, chunkE;

  always #5 clk = ~clk;

  complex_vector_demux_assembler #(.NI(NI), .ELEMENT_WIDTH(EW), .NUM_SLOTS(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (inReady2),
    .in_sel    (in_sel[0:0]),
    .addr_mode (addr_mode),
    .flush     (flush),
`ifdef COMPLEX_DEMUX_CONJ_EN
    .in_conj   (in_conj),
`endif
    .out_data  (outData2),
    .out_mask  (outMask2),
    .out_valid (outValid2),
    .out_ready (out_ready),
    .err_sel   (errSel2),
    .err_ovw   (errOvw2)
  );

  complex_vector_demux_assembler #(.NI(NI), .ELEMENT_WIDTH(EW), .NUM_SLOTS(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (inReady3),
    .in_sel    (in_sel),
    .addr_mode (addr_mode),
    .flush     (flush),
`ifdef COMPLEX_DEMUX_CONJ_EN
    .in_conj   (in_conj),
`endif
    .out_data  (outData3),
    .out_mask  (outMask3),
    .out_valid (outValid3),
    .out_ready (out_ready),
    .err_sel   (errSel3),
    .err_ovw   (errOvw3)
  );

  assign oReady[0]  = inReady2;
  assign oReady[1]  = inReady3;
  assign oValid[0]  = outValid2;
  assign oValid[1]  = outValid3;
  assign oErrSel[0] = errSel2;
  assign oErrSel[1] = errSel3;
  assign oErrOvw[0] = errOvw2;
  assign oErrOvw[1] = errOvw3;
  assign oData[0]   = {256'b0, outData2};
  assign oData[1]   = outData3;
  assign oMask[0]   = {1'b0, outMask2};
  assign oMask[1]   = outMask3;

  task automatic checkEq(input string tag, input logic [767:0] obs, input logic [767:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Value actually stored for a chunk: conjugation negates each 32-bit
  // imaginary half modulo 2^32.
  function automatic logic [CW-1:0] storedValue(input logic [CW-1:0] d, input bit conj);
    logic [CW-1:0] r;
    logic [31:0]   im;
    r = d;
    if (conj) begin
      for (int e = 0; e < NI / 2; e++) begin
        im = d[e*EW +: 32];
        r[e*EW +: 32] = 32'(33'h1_0000_0000 - {1'b0, im});
      end
    end
    return r;
  endfunction

  function automatic logic [767:0] expData(input int i);
    logic [767:0] r = '0;
    for (int k = 0; k < nSlots[i]; k++) r[k*CW +: CW] = mSlot[i][k];
    return r;
  endfunction

  function automatic logic [2:0] expMask(input int i);
    logic [2:0] r = '0;
    for (int k = 0; k < nSlots[i]; k++) r[k] = mFilled[i][k];
    return r;
  endfunction

  function automatic void modelReset(input int i);
    mHold[i] = 0; mPtr[i] = 0; mErrSel[i] = 0; mErrOvw[i] = 0;
    for (int k = 0; k < 3; k++) begin
      mFilled[i][k] = 0;
      mSlot[i][k]   = '0;
    end
  endfunction

  // Applies the assembler rules to the inputs seen at this clock edge.
  task automatic modelUpdate();
    int  s;
    int  filledCount;
    bit  conj;
    conj = 1'b0;
`ifdef COMPLEX_DEMUX_CONJ_EN
    conj = in_conj;
`endif
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        modelReset(i);
      end else if (mHold[i]) begin
        mErrSel[i] = 0; mErrOvw[i] = 0;
        if (out_ready) modelReset(i);
      end else begin
        mErrSel[i] = 0; mErrOvw[i] = 0;
        if (in_valid) begin
          if (addr_mode) s = (i == 0) ? int'(in_sel[0]) : int'(in_sel);
          else s = mPtr[i];
          if (s >= nSlots[i]) begin
            mErrSel[i] = 1;
          end else begin
            mErrOvw[i]    = mFilled[i][s];
            mFilled[i][s] = 1;
            mSlot[i][s]   = storedValue(in_data, conj);
          end
          if (!addr_mode) mPtr[i] = (mPtr[i] + 1) % nSlots[i];
        end
        filledCount = 0;
        for (int k = 0; k < nSlots[i]; k++) filledCount += int'(mFilled[i][k]);
        if (filledCount == nSlots[i]) mHold[i] = 1;
        else if (flush && filledCount > 0) mHold[i] = 1;
      end
    end
  endtask

  task automatic checkOutput();
    string n;
    for (int i = 0; i < 2; i++) begin
      n = $sformatf("dut%0d", nSlots[i]);
      checkEq({n, ".in_ready"},  768'(oReady[i]),  768'(!mHold[i]));
      checkEq({n, ".out_valid"}, 768'(oValid[i]),  768'(mHold[i]));
      checkEq({n, ".err_sel"},   768'(oErrSel[i]), 768'(mErrSel[i]));
      checkEq({n, ".err_ovw"},   768'(oErrOvw[i]), 768'(mErrOvw[i]));
      // Contents are defined while holding, and are all-zero whenever
      // nothing has been written since reset or the last handshake.
      if (mHold[i] || expMask(i) == 3'b000) begin
        checkEq({n, ".out_mask"}, 768'(oMask[i]), 768'(expMask(i)));
        checkEq({n, ".out_data"}, oData[i], expData(i));
      end
    end
  endtask

  // One clock under the currently driven inputs, then model and check.
  task automatic applyStimulus();
    @(posedge clk);
    modelUpdate();
    #1;
    checkOutput();
  endtask

  task automatic setIdle();
    in_valid = 0; flush = 0; addr_mode = 0; in_sel = 0; out_ready = 1; in_conj = 0;
  endtask

  task automatic pulseReset();
    setIdle();
    rst_n = 0;
    applyStimulus();
    rst_n = 1;
  endtask

  function automatic logic [CW-1:0] randChunk();
    logic [CW-1:0] r;
    for (int w = 0; w < CW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // Directed scenarios first, then a randomized stream.
  initial begin
    chunkA = {32{8'h11}};
    chunkB = {32{8'h22}};
    chunkC = {32{8'h33}};
    chunkD = {32{8'h44}};
    chunkE = {32{8'h55}};
    for (int i = 0; i < 2; i++) modelReset(i);

    setIdle();
    rst_n = 0; in_valid = 1; in_data = chunkA;
    applyStimulus();
    applyStimulus();
    checkEq("reset.out_data", oData[0], '0);
    checkEq("reset.in_ready", 768'(oReady[0]), 768'(1));
    rst_n = 1;
    setIdle();
    applyStimulus();

    // Auto fill of two chunks
    pulseReset();
    in_valid = 1; in_data = chunkA; applyStimulus();
    in_data = chunkB; applyStimulus();
    checkEq("auto.out_data", oData[0], {256'b0, chunkB, chunkA});
    checkEq("auto.out_mask", 768'(oMask[0]), 768'(2'b11));
    in_valid = 0; applyStimulus();
    checkEq("auto.in_ready_back", 768'(oReady[0]), 768'(1));

    // Addressed writes with overwrite
    pulseReset();
    in_valid = 1; addr_mode = 1;
    in_sel = 1; in_data = chunkC; applyStimulus();
    in_sel = 1; in_data = chunkD; applyStimulus();
    checkEq("addr.err_ovw", 768'(oErrOvw[0]), 768'(1));
    in_sel = 0; in_data = chunkE; applyStimulus();
    checkEq("addr.out_data", oData[0], {256'b0, chunkD, chunkE});
    setIdle(); applyStimulus();

    // Out-of-range select on the 3-slot instance
    pulseReset();
    in_valid = 1; addr_mode = 1; in_sel = 3; in_data = chunkA; applyStimulus();
    checkEq("sel.err_sel", 768'(oErrSel[1]), 768'(1));
    checkEq("sel.mask", 768'(oMask[1]), 768'(0));
    setIdle(); applyStimulus();

    // Flush of a partial vector under backpressure
    pulseReset();
    out_ready = 0;
    in_valid = 1; in_data = chunkA; applyStimulus();
    in_valid = 0; flush = 1; applyStimulus();
    checkEq("flush.out_mask", 768'(oMask[0]), 768'(2'b01));
    checkEq("flush.out_data", oData[0], {512'b0, chunkA});
    flush = 0; in_valid = 1; in_data = chunkB;
    for (int c = 0; c < 5; c++) applyStimulus();
    in_valid = 0; out_ready = 1; applyStimulus();
    in_valid = 1; in_data = chunkC; applyStimulus();
    in_valid = 0; flush = 1; applyStimulus();
    checkEq("flush.ptr_restart", 768'(oMask[0]), 768'(2'b01));
    setIdle(); applyStimulus();

    // Flush together with the first write, then flush on an empty block
    pulseReset();
    in_valid = 1; flush = 1; in_data = chunkD; applyStimulus();
    checkEq("flushwr.out_valid", 768'(oValid[0]), 768'(1));
    setIdle(); applyStimulus();
    flush = 1; applyStimulus();
    checkEq("flushempty.out_valid", 768'(oValid[0]), 768'(0));
    setIdle(); applyStimulus();

`ifdef COMPLEX_DEMUX_CONJ_EN
    pulseReset();
    in_data = randChunk();
    in_data[63:0]    = {32'd5, 32'd3};
    in_data[127:64]  = {32'd7, 32'h8000_0000};
    in_valid = 1; in_conj = 1; flush = 1; applyStimulus();
    checkEq("conj.elem0", 768'(oData[0][63:0]), 768'({32'd5, 32'hFFFF_FFFD}));
    checkEq("conj.elem1", 768'(oData[0][127:64]), 768'({32'd7, 32'h8000_0000}));
    setIdle(); applyStimulus();
`endif

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rst_n     = ($urandom_range(0, 59) != 0);
      in_valid  = ($urandom_range(0, 1) == 1);
      flush     = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      addr_mode = ($urandom_range(0, 2) == 0);
      in_sel    = 2'($urandom_range(0, 3));
      in_conj   = ($urandom_range(0, 1) == 1);
      in_data   = randChunk();
      applyStimulus();
    end

    setIdle();
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
